instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions, stages operands
// for an external ALU, and writes results back to two accumulators or data memory.
module instr_sequencer (
  input  logic        iClock,
  input  logic        iReset,
  output logic [9:0]  oInstAddr,
  output logic        oInstReq,
  input  logic        iInstValid,
  input  logic [15:0] iInstData,
  output logic [7:0]  oDataAddr,
  input  logic [7:0]  iDataRd,
  output logic [7:0]  oDataWr,
  output logic        oDataWe,
  output logic [7:0]  oAluOper1,
  output logic [7:0]  oAluOper2,
  output logic [5:0]  oAluInstSel,
  input  logic [7:0]  iAluData,
  input  logic        iBranchTaken,
  output logic [7:0]  oAccA,
  output logic [7:0]  oAccB
);

  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDB   = 6'h02;
  localparam logic [5:0] OP_LDCA  = 6'h03;
  localparam logic [5:0] OP_LDCB  = 6'h04;
  localparam logic [5:0] OP_STA   = 6'h05;
  localparam logic [5:0] OP_STB   = 6'h06;
  localparam logic [5:0] OP_ADDA  = 6'h07;
  localparam logic [5:0] OP_ADDB  = 6'h08;
  localparam logic [5:0] OP_ADDCA = 6'h09;
  localparam logic [5:0] OP_ADDCB = 6'h0A;
  localparam logic [5:0] OP_SUBA  = 6'h0B;
  localparam logic [5:0] OP_SUBB  = 6'h0C;
  localparam logic [5:0] OP_SUBCA = 6'h0D;
  localparam logic [5:0] OP_SUBCB = 6'h0E;
  localparam logic [5:0] OP_ANDA  = 6'h0F;
  localparam logic [5:0] OP_ANDB  = 6'h10;
  localparam logic [5:0] OP_ANDCA = 6'h11;
  localparam logic [5:0] OP_ANDCB = 6'h12;
  localparam logic [5:0] OP_ORA   = 6'h13;
  localparam logic [5:0] OP_ORB   = 6'h14;
  localparam logic [5:0] OP_ORCA  = 6'h15;
  localparam logic [5:0] OP_ORCB  = 6'h16;
  localparam logic [5:0] OP_ASLA  = 6'h17;
  localparam logic [5:0] OP_ASRA  = 6'h18;
  localparam logic [5:0] OP_JMP   = 6'h19;
  localparam logic [5:0] OP_BAEQ  = 6'h1A;
  localparam logic [5:0] OP_BANE  = 6'h1B;
  localparam logic [5:0] OP_BACS  = 6'h1C;
  localparam logic [5:0] OP_BACC  = 6'h1D;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPER, S_EXEC, S_WB} state_t;
  typedef enum logic [2:0] {SRC_ZERO, SRC_MEM, SRC_IMM, SRC_AB, SRC_A_IMM, SRC_IMM_B} src_t;

  state_t      state;
  logic [15:0] ir;
  logic [9:0]  pc;
  logic [7:0]  acc_a, acc_b;
  logic [7:0]  oper1, oper2;
  logic [5:0]  sel;
  logic [7:0]  alu_q;
  logic        branch_q;
  logic        inst_req;
  logic [7:0]  data_addr, data_wr;
  logic        data_we;

  logic [5:0]  opcode;
  logic [7:0]  imm;
  src_t        src;
  logic        wr_a, wr_b, is_store, is_jump;
  logic [7:0]  next_oper1, next_oper2;

  assign opcode = ir[15:10];
  assign imm    = ir[7:0];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    src      = SRC_ZERO;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    is_store = 1'b0;
    is_jump  = 1'b0;
    case (opcode)
      OP_LDA:  begin src = SRC_MEM; wr_a = 1'b1; end
      OP_LDB:  begin src = SRC_MEM; wr_b = 1'b1; end
      OP_LDCA: begin src = SRC_IMM; wr_a = 1'b1; end
      OP_LDCB: begin src = SRC_IMM; wr_b = 1'b1; end
      OP_STA, OP_STB: begin src = SRC_AB; is_store = 1'b1; end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA, OP_ASLA, OP_ASRA:
        begin src = SRC_AB; wr_a = 1'b1; end
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB:
        begin src = SRC_AB; wr_b = 1'b1; end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA:
        begin src = SRC_A_IMM; wr_a = 1'b1; end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB:
        begin src = SRC_IMM_B; wr_b = 1'b1; end
      OP_JMP, OP_BAEQ, OP_BANE, OP_BACS, OP_BACC: is_jump = 1'b1;
      default: ;  // unknown opcodes fall through as NOPs with zero operands
    endcase
  end

  always_comb begin
    next_oper1 = 8'h00;
    next_oper2 = 8'h00;
    case (src)
      SRC_MEM:   begin next_oper1 = iDataRd; next_oper2 = iDataRd; end
      SRC_IMM:   begin next_oper1 = imm;     next_oper2 = imm;     end
      SRC_AB:    begin next_oper1 = acc_a;   next_oper2 = acc_b;   end
      SRC_A_IMM: begin next_oper1 = acc_a;   next_oper2 = imm;     end
      SRC_IMM_B: begin next_oper1 = imm;     next_oper2 = acc_b;   end
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= S_FETCH;
      ir        <= 16'h0000;
      pc        <= 10'd0;
      acc_a     <= 8'h00;
      acc_b     <= 8'h00;
      oper1     <= 8'h00;
      oper2     <= 8'h00;
      sel       <= 6'h00;
      alu_q     <= 8'h00;
      branch_q  <= 1'b0;
      inst_req  <= 1'b1;
      data_addr <= 8'h00;
      data_wr   <= 8'h00;
      data_we   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (iInstValid) begin
          ir        <= iInstData;
          data_addr <= iInstData[7:0];
          inst_req  <= 1'b0;
          state     <= S_DECODE;
        end
        S_DECODE: state <= S_OPER;
        S_OPER: begin
          oper1 <= next_oper1;
          oper2 <= next_oper2;
          sel   <= opcode;
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_q    <= iAluData;
          branch_q <= iBranchTaken;
          // the store strobe is raised here so it is high for exactly the WB cycle
          if (is_store) begin
            data_we <= 1'b1;
            data_wr <= iAluData;
          end
          state <= S_WB;
        end
        S_WB: begin
          data_we <= 1'b0;
          if (wr_a) acc_a <= alu_q;
          if (wr_b) acc_b <= alu_q;
          pc       <= (is_jump && branch_q) ? ir[9:0] : pc + 10'd1;
          inst_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign oInstAddr   = pc;
  assign oInstReq    = inst_req;
  assign oDataAddr   = data_addr;
  assign oDataWr     = data_wr;
  assign oDataWe     = data_we;
  assign oAluOper1   = oper1;
  assign oAluOper2   = oper2;
  assign oAluInstSel = sel;
  assign oAccA       = acc_a;
  assign oAccB       = acc_b;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level model plus a per-cycle compare process,
// with a stand-in ALU and data memory driven from the DUT's own outputs.
module tb_instr_sequencer;

  localparam logic [5:0] OP_LDA   = 6'h01, OP_LDB   = 6'h02, OP_LDCA  = 6'h03, OP_LDCB  = 6'h04;
  localparam logic [5:0] OP_STA   = 6'h05, OP_STB   = 6'h06, OP_ADDA  = 6'h07, OP_ADDB  = 6'h08;
  localparam logic [5:0] OP_ADDCA = 6'h09, OP_ADDCB = 6'h0A, OP_SUBA  = 6'h0B, OP_SUBB  = 6'h0C;
  localparam logic [5:0] OP_SUBCA = 6'h0D, OP_SUBCB = 6'h0E, OP_ANDA  = 6'h0F, OP_ANDB  = 6'h10;
  localparam logic [5:0] OP_ANDCA = 6'h11, OP_ANDCB = 6'h12, OP_ORA   = 6'h13, OP_ORB   = 6'h14;
  localparam logic [5:0] OP_ORCA  = 6'h15, OP_ORCB  = 6'h16, OP_ASLA  = 6'h17, OP_ASRA  = 6'h18;
  localparam logic [5:0] OP_JMP   = 6'h19, OP_BAEQ  = 6'h1A, OP_BANE  = 6'h1B, OP_BACS  = 6'h1C;
  localparam logic [5:0] OP_BACC  = 6'h1D, OP_NOP   = 6'h3F;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [9:0]  oInstAddr;
  logic        oInstReq;
  logic        iInstValid;
  logic [15:0] iInstData;
  logic [7:0]  oDataAddr, iDataRd, oDataWr;
  logic        oDataWe;
  logic [7:0]  oAluOper1, oAluOper2;
  logic [5:0]  oAluInstSel;
  logic [7:0]  iAluData;
  logic        iBranchTaken;
  logic [7:0]  oAccA, oAccB;

  instr_sequencer dut (
    .iClock(iClock), .iReset(iReset),
    .oInstAddr(oInstAddr), .oInstReq(oInstReq),
    .iInstValid(iInstValid), .iInstData(iInstData),
    .oDataAddr(oDataAddr), .iDataRd(iDataRd), .oDataWr(oDataWr), .oDataWe(oDataWe),
    .oAluOper1(oAluOper1), .oAluOper2(oAluOper2), .oAluInstSel(oAluInstSel),
    .iAluData(iAluData), .iBranchTaken(iBranchTaken),
    .oAccA(oAccA), .oAccB(oAccB)
  );

  always #5 iClock = ~iClock;

  logic [15:0] imem [1024];
  logic [7:0]  dmem [256];
  logic [7:0]  m_mem [256];
  logic        inst_valid, branch_cond, chk_en;
  int          we_count;
  int          n_pass = 0, n_total = 0;

  // model architectural state and per-cycle expectations
  logic [7:0]  m_a, m_b;
  logic [9:0]  m_pc;
  logic        exp_req, exp_we;
  logic [7:0]  exp_daddr, exp_wr, exp_o1, exp_o2;
  logic [5:0]  exp_sel;

  assign iInstValid = inst_valid;
  assign iInstData  = inst_valid ? imem[oInstAddr] : 16'hFFFF;
  assign iDataRd    = dmem[oDataAddr];

  function automatic logic [7:0] alu_f(input logic [5:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      OP_LDA, OP_LDB, OP_LDCA, OP_LDCB, OP_STA: return a;
      OP_STB: return b;
      OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB: return a + b;
      OP_SUBA, OP_SUBCA: return a - b;
      OP_SUBB, OP_SUBCB: return b - a;
      OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: return a & b;
      OP_ORA, OP_ORB, OP_ORCA, OP_ORCB: return a | b;
      OP_ASLA: return {a[6:0], 1'b0};
      OP_ASRA: return {a[7], a[7:1]};
      default: return 8'h5A;
    endcase
  endfunction

  assign iAluData     = alu_f(oAluInstSel, oAluOper1, oAluOper2);
  assign iBranchTaken = (oAluInstSel == OP_JMP) ? 1'b1 : branch_cond;

  always @(negedge iClock) if (oDataWe) begin
    dmem[oDataAddr] = oDataWr;
    we_count = we_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge iClock) if (chk_en) begin
    check("inst_req",  32'(oInstReq),    32'(exp_req));
    check("inst_addr", 32'(oInstAddr),   32'(m_pc));
    check("data_we",   32'(oDataWe),     32'(exp_we));
    check("data_addr", 32'(oDataAddr),   32'(exp_daddr));
    check("alu_oper1", 32'(oAluOper1),   32'(exp_o1));
    check("alu_oper2", 32'(oAluOper2),   32'(exp_o2));
    check("alu_sel",   32'(oAluInstSel), 32'(exp_sel));
    check("acc_a",     32'(oAccA),       32'(m_a));
    check("acc_b",     32'(oAccB),       32'(m_b));
    if (exp_we) check("data_wr", 32'(oDataWr), 32'(exp_wr));
  end

  task automatic reset_model();
    m_a = 8'h00; m_b = 8'h00; m_pc = 10'd0;
    exp_req = 1'b1; exp_we = 1'b0; exp_daddr = 8'h00; exp_wr = 8'h00;
    exp_o1 = 8'h00; exp_o2 = 8'h00; exp_sel = 6'h00;
  endtask

  // Instruction-level semantics: operands the ALU must see, store data, next architectural state.
  task automatic model_step(input logic [5:0] op, input logic [7:0] imm, input logic [9:0] tgt,
                            input logic cond, output logic [7:0] o1, output logic [7:0] o2,
                            output logic [7:0] res, output logic st, output logic [7:0] na,
                            output logic [7:0] nb, output logic [9:0] npc);
    logic [7:0] mv;
    mv = m_mem[imm];
    o1 = 8'h00; o2 = 8'h00; res = 8'h00; st = 1'b0;
    na = m_a; nb = m_b; npc = m_pc + 10'd1;
    case (op)
      OP_LDA:   begin o1 = mv;  o2 = mv;  na = mv;  end
      OP_LDB:   begin o1 = mv;  o2 = mv;  nb = mv;  end
      OP_LDCA:  begin o1 = imm; o2 = imm; na = imm; end
      OP_LDCB:  begin o1 = imm; o2 = imm; nb = imm; end
      OP_STA:   begin o1 = m_a; o2 = m_b; res = m_a; st = 1'b1; end
      OP_STB:   begin o1 = m_a; o2 = m_b; res = m_b; st = 1'b1; end
      OP_ADDA:  begin o1 = m_a; o2 = m_b; na = m_a + m_b; end
      OP_ADDB:  begin o1 = m_a; o2 = m_b; nb = m_a + m_b; end
      OP_SUBA:  begin o1 = m_a; o2 = m_b; na = m_a - m_b; end
      OP_SUBB:  begin o1 = m_a; o2 = m_b; nb = m_b - m_a; end
      OP_ANDA:  begin o1 = m_a; o2 = m_b; na = m_a & m_b; end
      OP_ANDB:  begin o1 = m_a; o2 = m_b; nb = m_a & m_b; end
      OP_ORA:   begin o1 = m_a; o2 = m_b; na = m_a | m_b; end
      OP_ORB:   begin o1 = m_a; o2 = m_b; nb = m_a | m_b; end
      OP_ASLA:  begin o1 = m_a; o2 = m_b; na = {m_a[6:0], 1'b0}; end
      OP_ASRA:  begin o1 = m_a; o2 = m_b; na = {m_a[7], m_a[7:1]}; end
      OP_ADDCA: begin o1 = m_a; o2 = imm; na = m_a + imm; end
      OP_SUBCA: begin o1 = m_a; o2 = imm; na = m_a - imm; end
      OP_ANDCA: begin o1 = m_a; o2 = imm; na = m_a & imm; end
      OP_ORCA:  begin o1 = m_a; o2 = imm; na = m_a | imm; end
      OP_ADDCB: begin o1 = imm; o2 = m_b; nb = m_b + imm; end
      OP_SUBCB: begin o1 = imm; o2 = m_b; nb = m_b - imm; end
      OP_ANDCB: begin o1 = imm; o2 = m_b; nb = m_b & imm; end
      OP_ORCB:  begin o1 = imm; o2 = m_b; nb = m_b | imm; end
      OP_JMP:   npc = tgt;
      OP_BAEQ, OP_BANE, OP_BACS, OP_BACC: if (cond) npc = tgt;
      default:  ;
    endcase
  endtask

  // Runs the instruction at m_pc; called and returning 1 time unit after the edge entering FETCH.
  task automatic run_instr(input int stall, input bit late, input bit cond);
    logic [15:0] w;
    logic [7:0]  o1, o2, res, na, nb;
    logic [9:0]  npc;
    logic        st;
    w = imem[m_pc];
    branch_cond = cond;
    model_step(w[15:10], w[7:0], w[9:0], cond, o1, o2, res, st, na, nb, npc);
    for (int i = 0; i < stall; i++) begin
      inst_valid = 1'b0;
      @(posedge iClock); #1;
    end
    inst_valid = 1'b1;
    @(posedge iClock); #1;                       // DECODE
    exp_req = 1'b0; exp_daddr = w[7:0];
    if (late) inst_valid = 1'b0;
    @(posedge iClock); #1;                       // OPER
    if (late) inst_valid = 1'b1;
    @(posedge iClock); #1;                       // EXEC
    exp_o1 = o1; exp_o2 = o2; exp_sel = w[15:10];
    inst_valid = 1'b1;
    @(posedge iClock); #1;                       // WB
    if (st) begin exp_we = 1'b1; exp_wr = res; m_mem[w[7:0]] = res; end
    @(posedge iClock); #1;                       // next FETCH
    exp_we = 1'b0; exp_req = 1'b1;
    m_a = na; m_b = nb; m_pc = npc;
  endtask

  function automatic logic [15:0] ins(input logic [5:0] op, input logic [9:0] arg);
    return {op, arg};
  endfunction

  initial begin
    chk_en = 1'b0; inst_valid = 1'b1; branch_cond = 1'b0; we_count = 0;
    iReset = 1'b1;
    for (int i = 0; i < 1024; i++) imem[i] = ins(OP_NOP, 10'd0);
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'h00; m_mem[i] = 8'h00; end
    dmem[8'h10] = 8'hA5; m_mem[8'h10] = 8'hA5;

    imem[0]  = ins(OP_LDCA,  10'h005);
    imem[1]  = ins(OP_LDCB,  10'h003);
    imem[2]  = ins(OP_ADDA,  10'h000);
    imem[3]  = ins(OP_LDA,   10'h010);
    imem[4]  = ins(OP_STA,   10'h020);
    imem[5]  = ins(OP_SUBCB, 10'h001);
    imem[6]  = ins(OP_ASLA,  10'h000);
    imem[7]  = ins(OP_ORCA,  10'h001);
    imem[8]  = ins(OP_STB,   10'h021);
    imem[9]  = ins(OP_LDB,   10'h021);
    imem[10] = ins(OP_SUBA,  10'h000);
    imem[11] = ins(OP_SUBB,  10'h000);
    imem[12] = ins(OP_ANDA,  10'h000);
    imem[13] = ins(OP_LDCA,  10'h090);
    imem[14] = ins(OP_ASRA,  10'h000);
    imem[15] = ins(OP_ADDCB, 10'h010);
    imem[16] = ins(OP_ANDCA, 10'h00F);
    imem[17] = ins(OP_SUBCA, 10'h009);
    imem[18] = ins(OP_ADDB,  10'h000);
    imem[19] = ins(OP_ORA,   10'h000);
    imem[20] = ins(OP_NOP,   10'h0FF);
    imem[21] = ins(OP_BAEQ,  10'h040);
    imem[22] = ins(OP_BAEQ,  10'h040);
    imem[10'h040] = ins(OP_JMP, 10'h3FF);

    repeat (2) @(posedge iClock); #1;
    check("rst_inst_req",  32'(oInstReq),    32'd1);
    check("rst_inst_addr", 32'(oInstAddr),   32'd0);
    check("rst_data_we",   32'(oDataWe),     32'd0);
    check("rst_data_addr", 32'(oDataAddr),   32'd0);
    check("rst_data_wr",   32'(oDataWr),     32'd0);
    check("rst_acc_a",     32'(oAccA),       32'd0);
    check("rst_oper1",     32'(oAluOper1),   32'd0);
    check("rst_sel",       32'(oAluInstSel), 32'd0);
    reset_model();
    iReset = 1'b0;
    chk_en = 1'b1;

    // three back-to-back instructions with valid tied high: 15 cycles
    for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 1'b0);
    check("lit_add_acc_a", 32'(oAccA),     32'h08);
    check("lit_add_acc_b", 32'(oAccB),     32'h03);
    check("lit_add_pc",    32'(oInstAddr), 32'd3);

    we_count = 0;
    run_instr(0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0);
    check("lit_sta_pulses", 32'(we_count),    32'd1);
    check("lit_sta_mem",    32'(dmem[8'h20]), 32'hA5);
    check("lit_lda_acc_a",  32'(oAccA),       32'hA5);

    run_instr(4, 1'b0, 1'b0);                    // stalled fetch
    run_instr(0, 1'b0, 1'b1);                    // branch flag ignored by ASLA
    run_instr(0, 1'b1, 1'b0);                    // late valid pulse outside FETCH
    for (int i = 8; i < 20; i++) run_instr(i % 3, 1'b0, 1'b0);
    check("lit_asra_chain", 32'(m_a), 32'hFF);
    run_instr(0, 1'b0, 1'b1);                    // unknown opcode as NOP
    run_instr(0, 1'b0, 1'b0);                    // branch not taken
    check("lit_bra_nt_pc", 32'(oInstAddr), 32'd22);
    run_instr(0, 1'b0, 1'b1);                    // branch taken
    check("lit_bra_t_pc",  32'(oInstAddr), 32'h040);
    check("lit_bra_acc_a", 32'(oAccA),     32'hFF);
    check("lit_bra_acc_b", 32'(oAccB),     32'hC8);
    run_instr(0, 1'b0, 1'b0);
    check("lit_jmp_pc",    32'(oInstAddr), 32'h3FF);
    run_instr(0, 1'b0, 1'b0);
    check("lit_wrap_pc",   32'(oInstAddr), 32'h000);

    // reset in EXEC of ADDCA 0x01 must abort it
    chk_en = 1'b0;
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    imem[0] = ins(OP_ADDCA, 10'h001);
    repeat (3) @(posedge iClock); #1;
    check("exec_oper2", 32'(oAluOper2),   32'h01);
    check("exec_sel",   32'(oAluInstSel), 32'(OP_ADDCA));
    #2 iReset = 1'b1;
    #1;
    check("abort_acc_a",    32'(oAccA),     32'd0);
    check("abort_pc",       32'(oInstAddr), 32'd0);
    check("abort_inst_req", 32'(oInstReq),  32'd1);
    check("abort_oper2",    32'(oAluOper2), 32'd0);
    check("abort_data_we",  32'(oDataWe),   32'd0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    reset_model();
    chk_en = 1'b1;
    run_instr(0, 1'b0, 1'b0);
    check("lit_after_rst_a",  32'(oAccA),     32'h01);
    check("lit_after_rst_pc", 32'(oInstAddr), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
